// File: rtl/snake_motion_engine.sv
// -----------------------------------------------------------------------------
// snake_motion_engine
//
// Holds the snake's body coordinates and advances the snake by one grid step
// for each accepted move tick. A move runs as a short sequence:
//   CALC   - compute the candidate head and check it against the walls
//   SCAN   - compare the candidate head against one body entry per cycle
//   COMMIT - shift the body, place the new head, apply a pending grow/shrink
// A wall or body collision ends the game (DEAD) until the next start pulse.
//
// Configuration macro:
//   SNAKE_WRAP_EN - when defined, the walls are not fatal: a step off one edge
//                   re-enters at the opposite edge. Self-collision still kills.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   pulse; reload the initial snake and run (IDLE/DEAD only)
//   move_tick    in   pulse; request one move (honoured in RUN only)
//   dir_in       in   2'b00 right, 2'b01 left, 2'b10 up, 2'b11 down
//   dir_valid    in   latch dir_in (direct reversals are discarded)
//   grow_req     in   pulse; length +1 at the next commit
//   shrink_req   in   pulse; length -1 at the next commit
//   head_x/y     out  body entry 0
//   body_x_flat  out  entry k at [COORD_W*k +: COORD_W]
//   body_y_flat  out  entry k at [COORD_W*k +: COORD_W]
//   length       out  current snake length
//   busy         out  high while a move is being processed
//   moved        out  one-cycle pulse when a new head becomes visible
//   hit          out  one-cycle pulse on entering DEAD
//   alive        out  high in RUN and while a move is in progress
// -----------------------------------------------------------------------------
module snake_motion_engine #(
    parameter int COORD_W  = 11,
    parameter int MAX_LEN  = 63,
    parameter int LEN_W    = 6,
    parameter int AREA_W   = 136,
    parameter int AREA_H   = 76,
    parameter int STEP     = 10,
    parameter int INIT_X   = 60,
    parameter int INIT_Y   = 30,
    parameter int INIT_LEN = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           move_tick,
    input  logic [1:0]                     dir_in,
    input  logic                           dir_valid,
    input  logic                           grow_req,
    input  logic                           shrink_req,
    output logic [COORD_W-1:0]             head_x,
    output logic [COORD_W-1:0]             head_y,
    output logic [COORD_W*(MAX_LEN+1)-1:0] body_x_flat,
    output logic [COORD_W*(MAX_LEN+1)-1:0] body_y_flat,
    output logic [LEN_W-1:0]               length,
    output logic                           busy,
    output logic                           moved,
    output logic                           hit,
    output logic                           alive
);

    localparam int NUM_ENT = MAX_LEN + 1;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // One extra bit so that a step below zero shows up as the MSB.
    localparam logic [COORD_W:0] STEP_E   = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] AREA_W_E = (COORD_W+1)'(AREA_W);
    localparam logic [COORD_W:0] AREA_H_E = (COORD_W+1)'(AREA_H);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

`ifdef SNAKE_WRAP_EN
    // Last grid-aligned position that still fits inside the area.
    localparam logic [COORD_W-1:0] WRAP_X = COORD_W'(((AREA_W - STEP) / STEP) * STEP);
    localparam logic [COORD_W-1:0] WRAP_Y = COORD_W'(((AREA_H - STEP) / STEP) * STEP);
`endif

    typedef enum logic [2:0] {IDLE, RUN, CALC, SCAN, COMMIT, DEAD} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] pos_x [NUM_ENT];
    logic [COORD_W-1:0] pos_y [NUM_ENT];

    logic [1:0]         dir_req;    // direction the next CALC will use
    logic [1:0]         dir_last;   // direction of the last committed move
    logic [1:0]         dir_calc;   // direction used by the move in flight
    logic               grow_pend;
    logic               shrink_pend;
    logic [COORD_W-1:0] nx_q;
    logic [COORD_W-1:0] ny_q;
    logic [LEN_W-1:0]   scan_idx;
    logic [LEN_W-1:0]   scan_last;

    logic               load_init;
    logic               dir_reverse;
    logic               scan_match;
    logic               calc_wall;
    logic [COORD_W-1:0] calc_nx;
    logic [COORD_W-1:0] calc_ny;
    logic [COORD_W:0]   ext_x;
    logic [COORD_W:0]   ext_y;
    logic               under_x;
    logic               under_y;
    logic               over_x;
    logic               over_y;

    function automatic logic [COORD_W-1:0] init_x(input int k);
        return (k < INIT_LEN) ? COORD_W'(INIT_X - k * STEP) : '0;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int k);
        return (k < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
    endfunction

    assign load_init = start && ((state_q == IDLE) || (state_q == DEAD));

    // Right/left share bit 1 = 0 and up/down share bit 1 = 1, so a reversal
    // is "same axis, opposite sense".
    assign dir_reverse = (dir_in[1] == dir_last[1]) && (dir_in[0] != dir_last[0]);

    // The tail slot is vacated by this move unless the snake is growing,
    // so it only needs checking in the grow-only case.
    assign scan_last  = (grow_pend && !shrink_pend) ? (length - LEN_ONE) : (length - LEN_MIN);
    assign scan_match = (pos_x[scan_idx] == nx_q) && (pos_y[scan_idx] == ny_q);

    // ---------------------------------------------------------------- next head
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so
        // no path can leave one unassigned and infer a latch.
        ext_x = {1'b0, pos_x[0]};
        ext_y = {1'b0, pos_y[0]};
        case (dir_req)
            DIR_RIGHT: ext_x = ext_x + STEP_E;
            DIR_LEFT:  ext_x = ext_x - STEP_E;
            DIR_UP:    ext_y = ext_y - STEP_E;
            default:   ext_y = ext_y + STEP_E;
        endcase
        under_x = ext_x[COORD_W];
        under_y = ext_y[COORD_W];
        over_x  = (ext_x + STEP_E) > AREA_W_E;
        over_y  = (ext_y + STEP_E) > AREA_H_E;
`ifdef SNAKE_WRAP_EN
        calc_wall = 1'b0;
        if (under_x)     calc_nx = WRAP_X;
        else if (over_x) calc_nx = '0;
        else             calc_nx = ext_x[COORD_W-1:0];
        if (under_y)     calc_ny = WRAP_Y;
        else if (over_y) calc_ny = '0;
        else             calc_ny = ext_y[COORD_W-1:0];
`else
        calc_wall = under_x | under_y | over_x | over_y;
        calc_nx   = ext_x[COORD_W-1:0];
        calc_ny   = ext_y[COORD_W-1:0];
`endif
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (move_tick) state_d = CALC;
            CALC:    state_d = calc_wall ? DEAD : SCAN;
            SCAN: begin
                if (scan_match)                  state_d = DEAD;
                else if (scan_idx == scan_last)  state_d = COMMIT;
            end
            COMMIT:  state_d = RUN;
            DEAD:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            alive <= 1'b0;
            moved <= 1'b0;
            hit   <= 1'b0;
        end else begin
            busy  <= (state_d == CALC) || (state_d == SCAN) || (state_d == COMMIT);
            alive <= (state_d == RUN) || (state_d == CALC) ||
                     (state_d == SCAN) || (state_d == COMMIT);
            moved <= (state_q == COMMIT);
            hit   <= (state_d == DEAD) && (state_q != DEAD);
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the body array is deliberately reset: the display reads
            // every entry straight from these flops, and the reset image is
            // the initial snake.
            for (int k = 0; k < NUM_ENT; k++) begin
                pos_x[k] <= init_x(k);
                pos_y[k] <= init_y(k);
            end
            length      <= LEN_INIT;
            dir_req     <= DIR_RIGHT;
            dir_last    <= DIR_RIGHT;
            dir_calc    <= DIR_RIGHT;
            grow_pend   <= 1'b0;
            shrink_pend <= 1'b0;
            nx_q        <= '0;
            ny_q        <= '0;
            scan_idx    <= '0;
        end else if (load_init) begin
            for (int k = 0; k < NUM_ENT; k++) begin
                pos_x[k] <= init_x(k);
                pos_y[k] <= init_y(k);
            end
            length      <= LEN_INIT;
            dir_req     <= DIR_RIGHT;
            dir_last    <= DIR_RIGHT;
            dir_calc    <= DIR_RIGHT;
            grow_pend   <= 1'b0;
            shrink_pend <= 1'b0;
        end else begin
            if ((state_q != IDLE) && dir_valid && !dir_reverse)
                dir_req <= dir_in;

            // COMMIT consumes the pending flags, but a request arriving in
            // that same cycle is kept for the following move.
            grow_pend   <= (grow_pend && (state_q != COMMIT)) ||
                           (grow_req && (state_q != IDLE));
            shrink_pend <= (shrink_pend && (state_q != COMMIT)) ||
                           (shrink_req && (state_q != IDLE));

            case (state_q)
                CALC: begin
                    nx_q     <= calc_nx;
                    ny_q     <= calc_ny;
                    dir_calc <= dir_req;
                    scan_idx <= '0;
                end
                SCAN: scan_idx <= scan_idx + LEN_ONE;
                COMMIT: begin
                    for (int k = 1; k < MAX_LEN; k++) begin
                        pos_x[k] <= pos_x[k-1];
                        pos_y[k] <= pos_y[k-1];
                    end
                    pos_x[0] <= nx_q;
                    pos_y[0] <= ny_q;
                    if (grow_pend && !shrink_pend) begin
                        if (length < LEN_MAX) length <= length + LEN_ONE;
                    end else if (shrink_pend && !grow_pend) begin
                        if (length > LEN_MIN) length <= length - LEN_ONE;
                    end
                    dir_last <= dir_calc;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign head_x = pos_x[0];
    assign head_y = pos_y[0];

    for (genvar k = 0; k < NUM_ENT; k++) begin : g_flat
        assign body_x_flat[COORD_W*k +: COORD_W] = pos_x[k];
        assign body_y_flat[COORD_W*k +: COORD_W] = pos_y[k];
    end

endmodule
